// File: rtl/branch_resolve_bht_pkg.sv
// Shared types and helpers for the branch resolution unit and its bimodal predictor.
package branch_resolve_bht_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bht_state_t;

    function automatic bht_state_t sat_inc(input bht_state_t s);
        return (s == ST) ? ST : bht_state_t'(s + 2'd1);
    endfunction

    function automatic bht_state_t sat_dec(input bht_state_t s);
        return (s == SNT) ? SNT : bht_state_t'(s - 2'd1);
    endfunction

endpackage

// File: rtl/branch_resolve_bht_bimodal.sv
// Bimodal table of 2-bit saturating counters: combinational read, synchronous training.
module bht_bimodal
    import branch_resolve_bht_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             train,
    input  logic [IDX_W-1:0] train_idx,
    input  logic             train_taken
);

    bht_state_t tbl [ENTRIES];

    assign rd_taken = tbl[rd_idx] inside {WT, ST};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tbl[i] <= WNT;
            end
        end else if (train) begin
            tbl[train_idx] <= train_taken ? sat_inc(tbl[train_idx])
                                          : sat_dec(tbl[train_idx]);
        end
    end

endmodule

// File: rtl/branch_resolve_bht.sv
// Branch resolution: evaluates CTR/CR conditions, registers write-back and redirect, trains the BHT.
module branch_resolve_bht
    import branch_resolve_bht_pkg::*;
#(
    parameter int CTR_W       = 32,
    parameter int CR_W        = 32,
    parameter int PC_W        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int MISS_CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    flush,
    input  logic                    jump,
    input  logic                    dec_ctr,
    input  logic                    mask_ctr,
    input  logic                    ctr_eq,
    input  logic                    mask_cond,
    input  logic                    cond,
    input  logic [$clog2(CR_W)-1:0] crbi,
    input  logic                    save_link,
    input  logic [PC_W-1:0]         pc,
    input  logic [PC_W-1:0]         target,
    input  logic                    pred_taken,
    input  logic [CTR_W-1:0]        ctr_in,
    input  logic [CR_W-1:0]         cr_in,
    input  logic [PC_W-1:0]         lookup_pc,
    output logic                    lookup_taken,
    output logic                    jump_o,
    output logic                    mispredict,
    output logic [PC_W-1:0]         redirect_pc,
    output logic [CTR_W-1:0]        ctr_o,
    output logic                    ctr_we,
    output logic [PC_W-1:0]         lnk_o,
    output logic                    lnk_we,
    output logic [MISS_CNT_W-1:0]   miss_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic             accept;
    logic [CTR_W-1:0] ctr;
    logic             ctr_ok;
    logic             cond_ok;
    logic             taken;
    logic             miss;
    logic [PC_W-1:0]  pc_inc;
    logic             unused_pc_bits;

    assign accept  = en & ~flush;
    assign ctr     = dec_ctr ? ctr_in - CTR_W'(1) : ctr_in;
    assign ctr_ok  = mask_ctr | ((ctr != '0) ^ ctr_eq);
    // CR_W is a power of two, so CR_W-1-crbi is just the bitwise complement
    assign cond_ok = mask_cond | (cr_in[~crbi] == cond);
    assign taken   = jump | (ctr_ok & cond_ok);
    assign miss    = taken ^ pred_taken;
    assign pc_inc  = pc + PC_W'(4);

    assign unused_pc_bits = ^lookup_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            jump_o      <= 1'b0;
            mispredict  <= 1'b0;
            ctr_we      <= 1'b0;
            lnk_we      <= 1'b0;
            redirect_pc <= '0;
            ctr_o       <= '0;
            lnk_o       <= '0;
            miss_cnt    <= '0;
        end else begin
            jump_o     <= accept & taken;
            mispredict <= accept & miss;
            ctr_we     <= accept & dec_ctr;
            lnk_we     <= accept & save_link;
            if (accept) begin
                redirect_pc <= taken ? target : pc_inc;
                ctr_o       <= ctr;
                lnk_o       <= pc_inc;
            end
            if (accept && miss && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + MISS_CNT_W'(1);
            end
        end
    end

    bht_bimodal #(
        .ENTRIES(BHT_ENTRIES)
    ) u_bht (
        .clk        (clk),
        .reset      (reset),
        .rd_idx     (lookup_pc[IDX_W+1:2]),
        .rd_taken   (lookup_taken),
        .train      (accept),
        .train_idx  (pc[IDX_W+1:2]),
        .train_taken(taken)
    );

endmodule
